// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the instruction fetch unit.
package riscv_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer with synchronous active-low reset and flush.
// Flush wins over push; the entry type is a parameter.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           wdata,
    output entry_t           rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and fetch buffer feeding decode over valid/ready.
// Optional misaligned-redirect fault state under IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    localparam int         CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    logic [31:0]      r_pc;
    logic             w_halted;
    logic [31:0]      w_target;
    logic             w_pop;
    logic             w_push;
    fetch_entry_t     w_wdata;
    fetch_entry_t     w_head;
    logic [CNT_W-1:0] w_count_unused;
    logic             w_full;
    logic             w_empty;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= (redirect_pc[1:0] != 2'b00);
        end else begin
            r_fault <= r_fault;
        end
    end

    assign w_halted    = r_fault;
    assign w_target    = redirect_pc;
    assign fetch_fault = r_fault;
`else
    assign w_halted    = 1'b0;
    assign w_target    = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_fault = 1'b0;
`endif

    // A redirect flushes the buffer, so any fetch in the same cycle is dropped.
    always_comb begin
        w_pop         = !w_empty && out_ready;
        w_push        = !redirect_valid && !w_halted && (!w_full || w_pop);
        w_wdata.pc    = r_pc;
        w_wdata.instr = imem_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_target;
        end else if (w_push) begin
            r_pc <= pc_next(r_pc);
        end else begin
            r_pc <= r_pc;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count_unused),
        .full  (w_full),
        .empty (w_empty)
    );

    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule
